uart_rx_ctrl: RTL and testbench

UART receive path with its control-register handshake, the counterpart of the transmit-side control FSM. It synchronizes the serial line, detects and validates start bits, samples DATA_BITS data bits LSB-first at mid-bit, and checks the stop bit. On a valid frame it strobes the byte into the data register and raises a sticky "new data" flag. That flag stays set until the control register clears it. Framing and overrun errors are also reported.

---
 rtl/uart_rx_ctrl.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizes the serial line, validates the start
// bit, samples DATA_BITS data bits LSB-first at mid-bit, checks the stop bit,
// strobes good words into the data register and keeps the sticky status
// flags (new data, framing error, overrun) until the control register clears them.
module uart_rx_ctrl #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rx_i,
   input  logic                 clear_new_i,
   output logic [DATA_BITS-1:0] rx_data_o,
   output logic                 we_data_o,
   output logic                 new_rx_o,
   output logic                 frame_err_o,
   output logic                 overrun_o,
   output logic                 busy_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WRITE,
      S_BREAK
   } state_t;

   logic [1:0]           sync_reg;
   logic                 rx_s;
   state_t               state_reg, state_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic [IDX_W-1:0]     idx_reg, idx_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic [DATA_BITS-1:0] data_reg, data_next;
   logic                 new_reg, ferr_reg, ovr_reg;
   logic                 stop_bad;

   assign rx_s = sync_reg[1];

   // The stop bit is sampled low: the frame is broken and the word is dropped.
   assign stop_bad = (state_reg == S_STOP) && (cnt_reg == CNT_FULL) && !rx_s;

   // Two-flop synchronizer on the asynchronous line; idles high.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], rx_i};
      end
   end

   // State register together with the counters and data registers it steers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         shift_reg <= '0;
         data_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         shift_reg <= shift_next;
         data_reg  <= data_next;
      end
   end

   // Next-state logic: bit timing, sampling and frame validation.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      shift_next = shift_reg;
      data_next  = data_reg;
      case (state_reg)
         S_IDLE: begin
            cnt_next = '0;
            idx_next = '0;
            if (!rx_s) state_next = S_START;
         end
         S_START: begin
            if (cnt_reg == CNT_HALF) begin
               cnt_next   = '0;
               // A start bit that is high again at mid-bit was only a glitch.
               state_next = rx_s ? S_IDLE : S_DATA;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (cnt_reg == CNT_FULL) begin
               cnt_next            = '0;
               shift_next[idx_reg] = rx_s;
               if (idx_reg == IDX_LAST) state_next = S_STOP;
               else                     idx_next   = idx_reg + IDX_W'(1);
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (cnt_reg == CNT_FULL) begin
               cnt_next = '0;
               if (rx_s) begin
                  // Load here so the word is already on rx_data_o while we_data_o is high.
                  data_next  = shift_reg;
                  state_next = S_WRITE;
               end else begin
                  state_next = S_BREAK;
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_WRITE: begin
            cnt_next   = '0;
            idx_next   = '0;
            state_next = S_IDLE;
         end
         S_BREAK: begin
            // Hold off new starts until the line has returned high.
            cnt_next = '0;
            idx_next = '0;
            if (rx_s) state_next = S_IDLE;
         end
         default: begin
            cnt_next   = '0;
            idx_next   = '0;
            state_next = S_IDLE;
         end
      endcase
   end

   // Outputs decoded directly from the current state.
   always_comb begin
      we_data_o = 1'b0;
      busy_o    = 1'b1;
      if (state_reg == S_WRITE) we_data_o = 1'b1;
      if (state_reg == S_IDLE)  busy_o    = 1'b0;
   end

   // Sticky flags: a set in the same cycle as a clear wins for that flag only.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         new_reg  <= 1'b0;
         ferr_reg <= 1'b0;
         ovr_reg  <= 1'b0;
      end else begin
         if (state_reg == S_WRITE) new_reg <= 1'b1;
         else if (clear_new_i)     new_reg <= 1'b0;

         if (stop_bad)             ferr_reg <= 1'b1;
         else if (clear_new_i)     ferr_reg <= 1'b0;

         if ((state_reg == S_WRITE) && new_reg && !clear_new_i) ovr_reg <= 1'b1;
         else if (clear_new_i)                                  ovr_reg <= 1'b0;
      end
   end

   assign rx_data_o   = data_reg;
   assign new_rx_o    = new_reg;
   assign frame_err_o = ferr_reg;
   assign overrun_o   = ovr_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: serial frames are generated at bit
// level and the outcome is compared with a frame-level model of the data
// register and the sticky flags.
module tb_uart_rx_ctrl;

   localparam int CPB = 16;
   localparam int DB  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx;
   logic          clr;
   logic [DB-1:0] rx_data_o;
   logic          we_data_o;
   logic          new_rx_o;
   logic          frame_err_o;
   logic          overrun_o;
   logic          busy_o;

   int            n_cmp = 0;
   int            n_err = 0;

   // Observed write strobes: count of strobe cycles and word seen with each.
   int            we_cnt = 0;
   logic [7:0]    we_q[$];

   // Frame-level reference model.
   logic [7:0]    m_data;
   logic          m_new, m_ferr, m_ovr;
   int            m_we;

   uart_rx_ctrl #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DB)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .rx_i        (rx),
      .clear_new_i (clr),
      .rx_data_o   (rx_data_o),
      .we_data_o   (we_data_o),
      .new_rx_o    (new_rx_o),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   // Record every strobe cycle and the word presented with it.
   always @(negedge clk) begin
      if (we_data_o === 1'b1) begin
         we_cnt = we_cnt + 1;
         we_q.push_back(rx_data_o);
      end
   end

   task automatic model_reset();
      m_data = 8'h00; m_new = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
   endtask

   task automatic model_clear();
      m_new = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
   endtask

   // A good frame stores its word and raises new data; overrun if the previous
   // word was unread and not being cleared at that moment. A bad stop only
   // flags a framing error.
   task automatic model_frame(input logic [7:0] d, input logic stop_v, input logic clr_we);
      if (stop_v) begin
         if (clr_we) begin
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
         end else begin
            m_ovr = m_ovr | m_new;
         end
         m_new  = 1'b1;
         m_data = d;
         m_we   = m_we + 1;
      end else begin
         m_ferr = 1'b1;
      end
   endtask

   // Hold the line at v for n clocks; optionally pulse clear in the strobe cycle.
   task automatic drive_bit(input logic v, input int n, input logic clr_we);
      rx = v;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (clr_we && we_data_o === 1'b1) clr = 1'b1;
         @(posedge clk);
         #1;
         clr = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len,
                             input logic clr_we);
      $display("frame data=%h stop=%b stop_len=%0d clear_at_write=%b", d, stop_v, stop_len, clr_we);
      drive_bit(1'b0, CPB, 1'b0);
      for (int i = 0; i < DB; i++) drive_bit(d[i], CPB, 1'b0);
      drive_bit(stop_v, stop_len, clr_we);
      drive_bit(1'b1, 6, clr_we);
   endtask

   task automatic pulse_clear();
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      rst = 1'b1; rx = 1'b1; clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      m_we = 0;
      @(negedge clk);
      n_cmp++; if (rx_data_o !== 8'h00)  begin n_err++; $display("FAIL reset_data got=%h exp=00", rx_data_o); end
      n_cmp++; if (we_data_o !== 1'b0)   begin n_err++; $display("FAIL reset_we got=%b exp=0", we_data_o); end
      n_cmp++; if (new_rx_o !== 1'b0)    begin n_err++; $display("FAIL reset_new got=%b exp=0", new_rx_o); end
      n_cmp++; if (frame_err_o !== 1'b0) begin n_err++; $display("FAIL reset_ferr got=%b exp=0", frame_err_o); end
      n_cmp++; if (overrun_o !== 1'b0)   begin n_err++; $display("FAIL reset_ovr got=%b exp=0", overrun_o); end
      n_cmp++; if (busy_o !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_frame();
      logic [7:0] got;
      send_frame(8'hA5, 1'b1, CPB, 1'b0);
      model_frame(8'hA5, 1'b1, 1'b0);
      @(negedge clk);
      n_cmp++; if (we_cnt !== m_we) begin n_err++; $display("FAIL single_we_count got=%0d exp=%0d", we_cnt, m_we); end
      n_cmp++;
      if (we_q.size() == 0) begin n_err++; $display("FAIL single_strobe_data got=none exp=a5"); end
      else begin
         got = we_q.pop_front();
         if (got !== 8'hA5) begin n_err++; $display("FAIL single_strobe_data got=%h exp=a5", got); end
      end
      n_cmp++; if (rx_data_o !== m_data)   begin n_err++; $display("FAIL single_data got=%h exp=%h", rx_data_o, m_data); end
      n_cmp++; if (new_rx_o !== m_new)     begin n_err++; $display("FAIL single_new got=%b exp=%b", new_rx_o, m_new); end
      n_cmp++; if (frame_err_o !== m_ferr) begin n_err++; $display("FAIL single_ferr got=%b exp=%b", frame_err_o, m_ferr); end
      n_cmp++; if (overrun_o !== m_ovr)    begin n_err++; $display("FAIL single_ovr got=%b exp=%b", overrun_o, m_ovr); end
      n_cmp++; if (busy_o !== 1'b0)        begin n_err++; $display("FAIL single_busy got=%b exp=0", busy_o); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_glitch();
      pulse_clear();
      $display("glitch low for 4 cycles");
      drive_bit(1'b0, 4, 1'b0);
      rx = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL glitch_busy_start got=%b exp=1", busy_o); end
      repeat (8) @(posedge clk);
      #1;
      @(negedge clk);
      n_cmp++; if (busy_o !== 1'b0)        begin n_err++; $display("FAIL glitch_busy_end got=%b exp=0", busy_o); end
      n_cmp++; if (we_cnt !== m_we)        begin n_err++; $display("FAIL glitch_we_count got=%0d exp=%0d", we_cnt, m_we); end
      n_cmp++; if (new_rx_o !== m_new)     begin n_err++; $display("FAIL glitch_new got=%b exp=%b", new_rx_o, m_new); end
      n_cmp++; if (frame_err_o !== m_ferr) begin n_err++; $display("FAIL glitch_ferr got=%b exp=%b", frame_err_o, m_ferr); end
      n_cmp++; if (overrun_o !== m_ovr)    begin n_err++; $display("FAIL glitch_ovr got=%b exp=%b", overrun_o, m_ovr); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_frame_error();
      logic [7:0] d;
      logic [7:0] got;
      d = 8'h3C;
      $display("frame data=%h stop=0 line low 40 cycles", d);
      drive_bit(1'b0, CPB, 1'b0);
      for (int i = 0; i < DB; i++) drive_bit(d[i], CPB, 1'b0);
      drive_bit(1'b0, 30, 1'b0);
      model_frame(d, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++; if (frame_err_o !== 1'b1)   begin n_err++; $display("FAIL ferr_flag got=%b exp=1", frame_err_o); end
      n_cmp++; if (busy_o !== 1'b1)        begin n_err++; $display("FAIL ferr_break_busy got=%b exp=1", busy_o); end
      n_cmp++; if (we_cnt !== m_we)        begin n_err++; $display("FAIL ferr_we_count got=%0d exp=%0d", we_cnt, m_we); end
      n_cmp++; if (rx_data_o !== m_data)   begin n_err++; $display("FAIL ferr_data_kept got=%h exp=%h", rx_data_o, m_data); end
      @(posedge clk);
      #1;
      drive_bit(1'b0, 9, 1'b0);
      drive_bit(1'b1, 6, 1'b0);
      @(negedge clk);
      n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL ferr_break_exit got=%b exp=0", busy_o); end
      @(posedge clk);
      #1;
      send_frame(8'h55, 1'b1, CPB, 1'b0);
      model_frame(8'h55, 1'b1, 1'b0);
      @(negedge clk);
      n_cmp++; if (we_cnt !== m_we)        begin n_err++; $display("FAIL after_break_we_count got=%0d exp=%0d", we_cnt, m_we); end
      n_cmp++;
      if (we_q.size() == 0) begin n_err++; $display("FAIL after_break_strobe got=none exp=55"); end
      else begin
         got = we_q.pop_front();
         if (got !== 8'h55) begin n_err++; $display("FAIL after_break_strobe got=%h exp=55", got); end
      end
      n_cmp++; if (rx_data_o !== 8'h55)    begin n_err++; $display("FAIL after_break_data got=%h exp=55", rx_data_o); end
      n_cmp++; if (frame_err_o !== m_ferr) begin n_err++; $display("FAIL after_break_ferr got=%b exp=%b", frame_err_o, m_ferr); end
      n_cmp++; if (overrun_o !== m_ovr)    begin n_err++; $display("FAIL after_break_ovr got=%b exp=%b", overrun_o, m_ovr); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_overrun();
      pulse_clear();
      we_q.delete();
      send_frame(8'h11, 1'b1, CPB, 1'b0);
      model_frame(8'h11, 1'b1, 1'b0);
      @(negedge clk);
      n_cmp++; if (overrun_o !== m_ovr) begin n_err++; $display("FAIL ovr_first got=%b exp=%b", overrun_o, m_ovr); end
      @(posedge clk);
      #1;
      send_frame(8'h22, 1'b1, CPB, 1'b0);
      model_frame(8'h22, 1'b1, 1'b0);
      @(negedge clk);
      n_cmp++; if (overrun_o !== 1'b1)  begin n_err++; $display("FAIL ovr_second got=%b exp=1", overrun_o); end
      n_cmp++; if (rx_data_o !== 8'h22) begin n_err++; $display("FAIL ovr_data got=%h exp=22", rx_data_o); end
      n_cmp++; if (new_rx_o !== 1'b1)   begin n_err++; $display("FAIL ovr_new got=%b exp=1", new_rx_o); end
      @(posedge clk);
      #1;
      pulse_clear();
      @(negedge clk);
      n_cmp++; if (new_rx_o !== 1'b0)   begin n_err++; $display("FAIL ovr_clear_new got=%b exp=0", new_rx_o); end
      n_cmp++; if (overrun_o !== 1'b0)  begin n_err++; $display("FAIL ovr_clear_ovr got=%b exp=0", overrun_o); end
      n_cmp++; if (rx_data_o !== 8'h22) begin n_err++; $display("FAIL ovr_clear_data got=%h exp=22", rx_data_o); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_clear_at_write();
      send_frame(8'h33, 1'b1, CPB, 1'b0);
      model_frame(8'h33, 1'b1, 1'b0);
      send_frame(8'h7E, 1'b1, CPB, 1'b1);
      model_frame(8'h7E, 1'b1, 1'b1);
      @(negedge clk);
      n_cmp++; if (new_rx_o !== 1'b1)   begin n_err++; $display("FAIL clrwr_new got=%b exp=1", new_rx_o); end
      n_cmp++; if (overrun_o !== m_ovr) begin n_err++; $display("FAIL clrwr_ovr got=%b exp=%b", overrun_o, m_ovr); end
      n_cmp++; if (rx_data_o !== 8'h7E) begin n_err++; $display("FAIL clrwr_data got=%h exp=7e", rx_data_o); end
      n_cmp++; if (we_cnt !== m_we)     begin n_err++; $display("FAIL clrwr_we_count got=%0d exp=%0d", we_cnt, m_we); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      d = 8'hF0;
      $display("frame data=%h interrupted by reset in bit 3", d);
      drive_bit(1'b0, CPB, 1'b0);
      for (int i = 0; i < 3; i++) drive_bit(d[i], CPB, 1'b0);
      drive_bit(d[3], CPB / 2, 1'b0);
      rx  = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      n_cmp++; if (rx_data_o !== 8'h00)  begin n_err++; $display("FAIL midrst_data got=%h exp=00", rx_data_o); end
      n_cmp++; if (new_rx_o !== 1'b0)    begin n_err++; $display("FAIL midrst_new got=%b exp=0", new_rx_o); end
      n_cmp++; if (frame_err_o !== 1'b0) begin n_err++; $display("FAIL midrst_ferr got=%b exp=0", frame_err_o); end
      n_cmp++; if (overrun_o !== 1'b0)   begin n_err++; $display("FAIL midrst_ovr got=%b exp=0", overrun_o); end
      n_cmp++; if (busy_o !== 1'b0)      begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy_o); end
      @(posedge clk);
      #1;
      drive_bit(1'b1, 40, 1'b0);
      @(negedge clk);
      n_cmp++; if (we_cnt !== m_we) begin n_err++; $display("FAIL midrst_no_strobe got=%0d exp=%0d", we_cnt, m_we); end
      @(posedge clk);
      #1;
      send_frame(8'h0F, 1'b1, CPB, 1'b0);
      model_frame(8'h0F, 1'b1, 1'b0);
      @(negedge clk);
      n_cmp++; if (rx_data_o !== 8'h0F) begin n_err++; $display("FAIL midrst_next_data got=%h exp=0f", rx_data_o); end
      n_cmp++; if (we_cnt !== m_we)     begin n_err++; $display("FAIL midrst_next_we got=%0d exp=%0d", we_cnt, m_we); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic [7:0] got;
      logic       stop_v;
      logic       clr_we;
      int         stop_len;
      we_q.delete();
      for (int f = 0; f < 16; f++) begin
         d        = 8'($urandom);
         stop_v   = ($urandom_range(0, 4) != 0);
         clr_we   = stop_v && ($urandom_range(0, 3) == 0);
         stop_len = stop_v ? CPB : CPB + int'($urandom_range(0, 20));
         if ($urandom_range(0, 2) == 0) pulse_clear();
         send_frame(d, stop_v, stop_len, clr_we);
         model_frame(d, stop_v, clr_we);
         @(negedge clk);
         n_cmp++; if (we_cnt !== m_we)        begin n_err++; $display("FAIL rnd%0d_we_count got=%0d exp=%0d", f, we_cnt, m_we); end
         n_cmp++; if (rx_data_o !== m_data)   begin n_err++; $display("FAIL rnd%0d_data got=%h exp=%h", f, rx_data_o, m_data); end
         n_cmp++; if (new_rx_o !== m_new)     begin n_err++; $display("FAIL rnd%0d_new got=%b exp=%b", f, new_rx_o, m_new); end
         n_cmp++; if (frame_err_o !== m_ferr) begin n_err++; $display("FAIL rnd%0d_ferr got=%b exp=%b", f, frame_err_o, m_ferr); end
         n_cmp++; if (overrun_o !== m_ovr)    begin n_err++; $display("FAIL rnd%0d_ovr got=%b exp=%b", f, overrun_o, m_ovr); end
         n_cmp++; if (busy_o !== 1'b0)        begin n_err++; $display("FAIL rnd%0d_busy got=%b exp=0", f, busy_o); end
         if (stop_v) begin
            n_cmp++;
            if (we_q.size() == 0) begin n_err++; $display("FAIL rnd%0d_strobe got=none exp=%h", f, d); end
            else begin
               got = we_q.pop_front();
               if (got !== d) begin n_err++; $display("FAIL rnd%0d_strobe got=%h exp=%h", f, got, d); end
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      clr = 1'b0;
      m_we = 0;
      model_reset();
      test_reset();
      test_single_frame();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_clear_at_write();
      test_reset_mid_frame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
